// File: rtl/psone_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : psone_frame_tx
// Purpose  : Double-buffers pad-poll bytes and streams each completed poll to
//            the UART as HDR / LEN / payload [/ XOR] frames.
//            Optional checksum byte: define PSONE_FRAME_CSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module psone_frame_tx #(
    parameter int         MAX_BYTES = 9,
    parameter logic [7:0] HDR       = 8'hA5
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iBYTE_VALID,
    input  logic [7:0] iBYTE,
    input  logic       iPOLL_END,
    input  logic       iTRAN_BUSY,
    output logic       oTRAN_ST,
    output logic [7:0] oTX_BYTE,
    output logic       oBUSY,
    output logic [7:0] oDROP_CNT,
    output logic       oOVF
);
    localparam int         AW    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [7:0] c_MAX = 8'(MAX_BYTES);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_HDR  = 3'd1;
    localparam logic [2:0] c_ST_LEN  = 3'd2;
    localparam logic [2:0] c_ST_DATA = 3'd3;
`ifdef PSONE_FRAME_CSUM_EN
    localparam logic [2:0] c_ST_CSUM = 3'd4;
`endif
    localparam logic [2:0] c_ST_WAIT = 3'd5;

    logic [7:0] bank0_q [MAX_BYTES];
    logic [7:0] bank1_q [MAX_BYTES];

    logic [2:0] state_q, state_d;
    logic [2:0] ret_q, ret_d;
    logic       wait_first_q;
    logic       snd_sel_q, snd_sel_d;
    logic       pend_q, pend_d;
    logic [7:0] cap_cnt_q, cap_cnt_d;
    logic [7:0] len0_q, len0_d;
    logic [7:0] len1_q, len1_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] drop_q, drop_d;
    logic       ovf_q, ovf_d;
`ifdef PSONE_FRAME_CSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    logic       w_cap_wr;
    logic [7:0] w_cnt_after;
    logic       w_done;
    logic       w_start;
    logic       w_issue;
    logic       w_frame_end;
    logic       w_take;
    logic [7:0] w_snd_len;
    logic [7:0] w_snd_byte;
    logic       w_last_idx;

    // snd_sel_q selects the bank being sent; capture always targets the other.
    assign w_cap_wr    = iBYTE_VALID && (cap_cnt_q != c_MAX);
    assign w_cnt_after = w_cap_wr ? (cap_cnt_q + 8'd1) : cap_cnt_q;
    assign w_done      = iPOLL_END && (w_cnt_after != 8'd0);
    assign w_start     = w_done && (state_q == c_ST_IDLE);
    assign w_snd_len   = snd_sel_q ? len1_q : len0_q;
    assign w_snd_byte  = snd_sel_q ? bank1_q[idx_q[AW-1:0]] : bank0_q[idx_q[AW-1:0]];
    assign w_last_idx  = (idx_q == (w_snd_len - 8'd1));
    assign w_frame_end = (state_q == c_ST_WAIT) && !wait_first_q && !iTRAN_BUSY
                         && (ret_q == c_ST_IDLE);
    assign w_take      = w_frame_end && (pend_q || w_done);

    always_comb begin
        w_issue = 1'b0;
        if ((state_q == c_ST_HDR) || (state_q == c_ST_LEN) || (state_q == c_ST_DATA))
            w_issue = !iTRAN_BUSY;
`ifdef PSONE_FRAME_CSUM_EN
        if (state_q == c_ST_CSUM)
            w_issue = !iTRAN_BUSY;
`endif
    end

    always_ff @(posedge iCLK) begin
        if (w_cap_wr) begin
            if (snd_sel_q)
                bank0_q[cap_cnt_q[AW-1:0]] <= iBYTE;
            else
                bank1_q[cap_cnt_q[AW-1:0]] <= iBYTE;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q      <= c_ST_IDLE;
            ret_q        <= c_ST_IDLE;
            wait_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            wait_first_q <= (state_d == c_ST_WAIT) && (state_q != c_ST_WAIT);
        end
    end

    // A return target of IDLE marks the last byte of the frame.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        case (state_q)
            c_ST_IDLE: if (w_start) state_d = c_ST_HDR;
            c_ST_HDR:  if (w_issue) begin state_d = c_ST_WAIT; ret_d = c_ST_LEN;  end
            c_ST_LEN:  if (w_issue) begin state_d = c_ST_WAIT; ret_d = c_ST_DATA; end
            c_ST_DATA: if (w_issue) begin
                state_d = c_ST_WAIT;
`ifdef PSONE_FRAME_CSUM_EN
                ret_d   = w_last_idx ? c_ST_CSUM : c_ST_DATA;
`else
                ret_d   = w_last_idx ? c_ST_IDLE : c_ST_DATA;
`endif
            end
`ifdef PSONE_FRAME_CSUM_EN
            c_ST_CSUM: if (w_issue) begin state_d = c_ST_WAIT; ret_d = c_ST_IDLE; end
`endif
            c_ST_WAIT: if (!wait_first_q && !iTRAN_BUSY) begin
                if (ret_q == c_ST_IDLE)
                    state_d = w_take ? c_ST_HDR : c_ST_IDLE;
                else
                    state_d = ret_q;
            end
            default:   state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        oTRAN_ST  = w_issue;
        oTX_BYTE  = tx_q;
        oBUSY     = (state_q != c_ST_IDLE) || pend_q;
        oDROP_CNT = drop_q;
        oOVF      = ovf_q;
    end

    always_comb begin
        snd_sel_d = snd_sel_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        ovf_d     = ovf_q;
        cap_cnt_d = w_done ? 8'd0 : w_cnt_after;
        len0_d    = len0_q;
        len1_d    = len1_q;
        idx_d     = idx_q;
        tx_d      = tx_q;
`ifdef PSONE_FRAME_CSUM_EN
        csum_d    = csum_q;
`endif
        if (iBYTE_VALID && (cap_cnt_q == c_MAX))
            ovf_d = 1'b1;
        if (w_done) begin
            if (snd_sel_q) len0_d = w_cnt_after;
            else           len1_d = w_cnt_after;
            if (pend_q && (drop_q != 8'hFF))
                drop_d = drop_q + 8'd1;
        end
        if (w_start || w_take) begin
            snd_sel_d = ~snd_sel_q;
            pend_d    = 1'b0;
        end else if (w_done) begin
            pend_d    = 1'b1;
        end
        if (state_q == c_ST_HDR) begin
            idx_d  = 8'd0;
`ifdef PSONE_FRAME_CSUM_EN
            csum_d = 8'd0;
`endif
        end else if ((state_q == c_ST_DATA) && w_issue) begin
            idx_d  = idx_q + 8'd1;
`ifdef PSONE_FRAME_CSUM_EN
            csum_d = csum_q ^ w_snd_byte;
`endif
        end
        // The byte register is loaded on entry so it is valid in the pulse cycle.
        if (state_d != state_q) begin
            case (state_d)
                c_ST_HDR:  tx_d = HDR;
                c_ST_LEN:  tx_d = w_snd_len;
                c_ST_DATA: tx_d = w_snd_byte;
`ifdef PSONE_FRAME_CSUM_EN
                c_ST_CSUM: tx_d = csum_q;
`endif
                default:   tx_d = tx_q;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            snd_sel_q <= 1'b1;
            pend_q    <= 1'b0;
            drop_q    <= 8'd0;
            ovf_q     <= 1'b0;
            cap_cnt_q <= 8'd0;
            len0_q    <= 8'd0;
            len1_q    <= 8'd0;
            idx_q     <= 8'd0;
            tx_q      <= 8'd0;
`ifdef PSONE_FRAME_CSUM_EN
            csum_q    <= 8'd0;
`endif
        end else begin
            snd_sel_q <= snd_sel_d;
            pend_q    <= pend_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
            cap_cnt_q <= cap_cnt_d;
            len0_q    <= len0_d;
            len1_q    <= len1_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
`ifdef PSONE_FRAME_CSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psone_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_psone_frame_tx
// Purpose  : Self-checking bench for psone_frame_tx with a UART busy model and
//            a frame-level reference model (honours PSONE_FRAME_CSUM_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_psone_frame_tx;
    localparam int MAXB = 9;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iBYTE_VALID;
    logic [7:0] iBYTE;
    logic       iPOLL_END;
    logic       tran_busy = 1'b0;
    logic       oTRAN_ST;
    logic [7:0] oTX_BYTE;
    logic       oBUSY;
    logic [7:0] oDROP_CNT;
    logic       oOVF;

    int errors = 0;
    int checks = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] poll_q[$];

    int cyc        = 0;
    int last_pulse = -100;
    int min_gap    = 1000;
    int busy_cnt   = 0;
    bit busy_arm   = 1'b0;
    bit busy_seen  = 1'b0;

    psone_frame_tx #(.MAX_BYTES(MAXB), .HDR(8'hA5)) dut (
        .iCLK       (clk),
        .iRESET     (rst_n),
        .iBYTE_VALID(iBYTE_VALID),
        .iBYTE      (iBYTE),
        .iPOLL_END  (iPOLL_END),
        .iTRAN_BUSY (tran_busy),
        .oTRAN_ST   (oTRAN_ST),
        .oTX_BYTE   (oTX_BYTE),
        .oBUSY      (oBUSY),
        .oDROP_CNT  (oDROP_CNT),
        .oOVF       (oOVF)
    );

    always #5 clk = ~clk;

    // UART model: goes busy one cycle after a start pulse for 1..4 cycles.
    always @(negedge clk) begin
        cyc++;
        if (oBUSY) busy_seen = 1'b1;
        if (rst_n && oTRAN_ST) begin
            got_q.push_back(oTX_BYTE);
            if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
        if (!rst_n) begin
            tran_busy = 1'b0;
            busy_arm  = 1'b0;
            busy_cnt  = 0;
        end else if (busy_arm) begin
            tran_busy = 1'b1;
            busy_cnt  = $urandom_range(1, 4);
            busy_arm  = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tran_busy = 1'b0;
        end
        if (rst_n && oTRAN_ST) busy_arm = 1'b1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference frame: header, truncated length, payload, optional XOR.
    task automatic add_expected();
        int n;
        logic [7:0] x;
        n = (poll_q.size() > MAXB) ? MAXB : poll_q.size();
        x = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(poll_q[i]);
            x = x ^ poll_q[i];
        end
`ifdef PSONE_FRAME_CSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic drive_poll(input bit same);
        for (int i = 0; i < poll_q.size(); i++) begin
            @(negedge clk);
            iBYTE_VALID = 1'b1;
            iBYTE       = poll_q[i];
            iPOLL_END   = same && (i == poll_q.size() - 1);
        end
        if (!same || poll_q.size() == 0) begin
            @(negedge clk);
            iBYTE_VALID = 1'b0;
            iPOLL_END   = 1'b1;
        end
        @(negedge clk);
        iBYTE_VALID = 1'b0;
        iPOLL_END   = 1'b0;
    endtask

    task automatic rand_poll(input int n);
        poll_q.delete();
        for (int i = 0; i < n; i++) poll_q.push_back(8'($urandom));
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (oBUSY !== 1'b0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, {31'd0, oBUSY}, 32'd0);
    endtask

    task automatic check_frames(input string tag);
        logic [7:0] g;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = 8'hxx;
            if (i < got_q.size()) g = got_q[i];
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, g}, {24'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        iBYTE_VALID = 1'b0;
        iBYTE       = 8'h00;
        iPOLL_END   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_st",   {31'd0, oTRAN_ST}, 32'd0);
        chk("rst_tx",   {24'd0, oTX_BYTE}, 32'd0);
        chk("rst_busy", {31'd0, oBUSY},    32'd0);
        chk("rst_drop", {24'd0, oDROP_CNT}, 32'd0);
        chk("rst_ovf",  {31'd0, oOVF},     32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reference poll, end strobe after the last byte.
        poll_q = '{8'hFF, 8'h73, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        add_expected();
        drive_poll(1'b0);
        chk("t1_lat_st", {31'd0, oTRAN_ST}, 32'd1);
        chk("t1_lat_tx", {24'd0, oTX_BYTE}, 32'hA5);
        wait_idle("t1");
        check_frames("t1");

        // Last byte coincides with the end strobe.
        add_expected();
        drive_poll(1'b1);
        chk("t2_lat_st", {31'd0, oTRAN_ST}, 32'd1);
        wait_idle("t2");
        check_frames("t2");
        chk("t2_ovf", {31'd0, oOVF}, 32'd0);

        // Overflow: 11 bytes into a 9-byte bank.
        rand_poll(11);
        add_expected();
        drive_poll(1'b0);
        wait_idle("t3");
        check_frames("t3");
        chk("t3_ovf", {31'd0, oOVF}, 32'd1);

        // Overlap: second poll is replaced by the third.
        poll_q = '{8'h01};
        add_expected();
        drive_poll(1'b0);
        poll_q = '{8'h02};
        drive_poll(1'b0);
        poll_q = '{8'h03};
        add_expected();
        drive_poll(1'b0);
        wait_idle("t4");
        check_frames("t4");
        chk("t4_drop", {24'd0, oDROP_CNT}, 32'd1);

        // Empty poll.
        repeat (3) @(negedge clk);
        busy_seen = 1'b0;
        poll_q.delete();
        drive_poll(1'b0);
        repeat (20) @(negedge clk);
        chk("t5_pulses", got_q.size(), 32'd0);
        chk("t5_busy",   {31'd0, busy_seen}, 32'd0);

        // Random polls against the reference.
        for (int r = 0; r < 8; r++) begin
            rand_poll($urandom_range(1, 11));
            add_expected();
            drive_poll(1'($urandom_range(0, 1)));
            wait_idle($sformatf("t6_%0d", r));
            check_frames($sformatf("t6_%0d", r));
        end
        chk("t6_ovf_sticky", {31'd0, oOVF}, 32'd1);

        // Asynchronous reset in the middle of the payload.
        rand_poll(9);
        drive_poll(1'b0);
        for (int k = 0; k < 200 && got_q.size() < 4; k++) @(negedge clk);
        chk("t7_reached", {31'd0, got_q.size() >= 4}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_st",   {31'd0, oTRAN_ST}, 32'd0);
        chk("t7_tx",   {24'd0, oTX_BYTE}, 32'd0);
        chk("t7_busy", {31'd0, oBUSY},    32'd0);
        chk("t7_drop", {24'd0, oDROP_CNT}, 32'd0);
        chk("t7_ovf",  {31'd0, oOVF},     32'd0);
        @(negedge clk);
        got_q.delete();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("t7_silent", got_q.size(), 32'd0);
        rand_poll(5);
        add_expected();
        drive_poll(1'b0);
        wait_idle("t7b");
        check_frames("t7b");

        chk("pulse_gap", {31'd0, min_gap >= 2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
